// File: rtl/v_pkg.sv
// ============================================================================
// Module : v_pkg
// Brief  : Shared list-update types, scheduler FSM encoding and defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package v_pkg;

   typedef logic [7:0]  id_t;
   typedef logic [2:0]  cmd_t;
   typedef logic [15:0] key_t;
   typedef logic [11:0] size_t;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } sched_state_t;

   localparam int SCHED_HAZARD_DEPTH = 5;

endpackage

`default_nettype wire

// File: rtl/v_rr_arb.sv
// ============================================================================
// Module : v_rr_arb
// Brief  : Round-robin one-hot selector; first request at or above i_ptr wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module v_rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt
);

   localparam int SW = PW + 1;

   logic [SW-1:0] w_sum;
   logic [PW-1:0] w_idx;

   // Walk from the farthest offset down so the closest request overwrites last.
   always_comb begin
      o_gnt = '0;
      w_sum = '0;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + SW'(k);
         if (w_sum >= SW'(N)) begin
            w_sum = w_sum - SW'(N);
         end
         w_idx = w_sum[PW-1:0];
         if (i_req[w_idx]) begin
            o_gnt        = '0;
            o_gnt[w_idx] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/v_upd_sched.sv
// ============================================================================
// Module : v_upd_sched
// Brief  : Round-robin list-update scheduler with per-product hazard blocking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module v_upd_sched
   import v_pkg::*;
#(
   parameter int REQ_N        = 4,
   parameter int HAZARD_DEPTH = SCHED_HAZARD_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REQ_N-1:0]        i_req_vld,
   input  id_t   [REQ_N-1:0]       i_req_prod_id,
   input  cmd_t  [REQ_N-1:0]       i_req_cmd,
   input  key_t  [REQ_N-1:0]       i_req_key,
   input  size_t [REQ_N-1:0]       i_req_size,
   output logic [REQ_N-1:0]        o_req_rdy,
   input  logic                    i_busy,
   output logic                    o_upd_vld_r,
   output id_t                     o_upd_prod_id_r,
   output cmd_t                    o_upd_cmd_r,
   output key_t                    o_upd_key_r,
   output size_t                   o_upd_size_r,
   output logic                    o_stall_r
);

   localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

   sched_state_t                r_state_q, w_state_d;
   logic [PW-1:0]               r_ptr_q, w_ptr_d;
   logic [HAZARD_DEPTH-1:0]     r_hist_vld_q, w_hist_vld_d;
   id_t  [HAZARD_DEPTH-1:0]     r_hist_id_q, w_hist_id_d;
   logic                        r_upd_vld_q, w_upd_vld_d;
   id_t                         r_upd_prod_id_q, w_upd_prod_id_d;
   cmd_t                        r_upd_cmd_q, w_upd_cmd_d;
   key_t                        r_upd_key_q, w_upd_key_d;
   size_t                       r_upd_size_q, w_upd_size_d;
   logic                        r_stall_q, w_stall_d;

   logic [REQ_N-1:0]            w_elig;
   logic [REQ_N-1:0]            w_gnt;
   logic                        w_gnt_any;
   logic [PW-1:0]               w_gnt_idx;

   always_comb begin
      w_state_d = r_state_q;
      case (r_state_q)
         ST_INIT: if (!i_busy) w_state_d = ST_RUN;
         ST_RUN:  if (i_busy)  w_state_d = ST_HOLD;
         ST_HOLD: if (!i_busy) w_state_d = ST_RUN;
         default:              w_state_d = ST_INIT;
      endcase
   end

   // rst gates eligibility so no grant is issued in the cycle reset is sampled.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < REQ_N; i++) begin
         w_elig[i] = i_req_vld[i];
         for (int j = 0; j < HAZARD_DEPTH; j++) begin
            if (r_hist_vld_q[j] && (r_hist_id_q[j] == i_req_prod_id[i])) begin
               w_elig[i] = 1'b0;
            end
         end
      end
      if (rst || i_busy || (r_state_q != ST_RUN)) begin
         w_elig = '0;
      end
   end

   v_rr_arb #(
      .N  (REQ_N),
      .PW (PW)
   ) u_rr_arb (
      .i_req (w_elig),
      .i_ptr (r_ptr_q),
      .o_gnt (w_gnt)
   );

   assign o_req_rdy = w_gnt;
   assign w_gnt_any = |w_gnt;

   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < REQ_N; i++) begin
         if (w_gnt[i]) w_gnt_idx = PW'(i);
      end
   end

   always_comb begin
      w_ptr_d         = r_ptr_q;
      w_upd_vld_d     = w_gnt_any;
      w_upd_prod_id_d = r_upd_prod_id_q;
      w_upd_cmd_d     = r_upd_cmd_q;
      w_upd_key_d     = r_upd_key_q;
      w_upd_size_d    = r_upd_size_q;
      w_stall_d       = (|i_req_vld) && !w_gnt_any;
      if (w_gnt_any) begin
         w_ptr_d         = (w_gnt_idx == PW'(REQ_N - 1)) ? '0 : w_gnt_idx + PW'(1);
         w_upd_prod_id_d = i_req_prod_id[w_gnt_idx];
         w_upd_cmd_d     = i_req_cmd[w_gnt_idx];
         w_upd_key_d     = i_req_key[w_gnt_idx];
         w_upd_size_d    = i_req_size[w_gnt_idx];
      end
   end

   // History shifts every cycle; an empty slot is pushed when nothing is granted.
   always_comb begin
      w_hist_vld_d = r_hist_vld_q;
      w_hist_id_d  = r_hist_id_q;
      for (int j = HAZARD_DEPTH - 1; j > 0; j--) begin
         w_hist_vld_d[j] = r_hist_vld_q[j-1];
         w_hist_id_d[j]  = r_hist_id_q[j-1];
      end
      w_hist_vld_d[0] = w_gnt_any;
      w_hist_id_d[0]  = i_req_prod_id[w_gnt_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q       <= ST_INIT;
         r_ptr_q         <= '0;
         r_hist_vld_q    <= '0;
         r_hist_id_q     <= '0;
         r_upd_vld_q     <= 1'b0;
         r_upd_prod_id_q <= '0;
         r_upd_cmd_q     <= '0;
         r_upd_key_q     <= '0;
         r_upd_size_q    <= '0;
         r_stall_q       <= 1'b0;
      end else begin
         r_state_q       <= w_state_d;
         r_ptr_q         <= w_ptr_d;
         r_hist_vld_q    <= w_hist_vld_d;
         r_hist_id_q     <= w_hist_id_d;
         r_upd_vld_q     <= w_upd_vld_d;
         r_upd_prod_id_q <= w_upd_prod_id_d;
         r_upd_cmd_q     <= w_upd_cmd_d;
         r_upd_key_q     <= w_upd_key_d;
         r_upd_size_q    <= w_upd_size_d;
         r_stall_q       <= w_stall_d;
      end
   end

   assign o_upd_vld_r     = r_upd_vld_q;
   assign o_upd_prod_id_r = r_upd_prod_id_q;
   assign o_upd_cmd_r     = r_upd_cmd_q;
   assign o_upd_key_r     = r_upd_key_q;
   assign o_upd_size_r    = r_upd_size_q;
   assign o_stall_r       = r_stall_q;

endmodule

`default_nettype wire

// File: tb/tb_v_upd_sched.sv
// ============================================================================
// Module : tb_v_upd_sched
// Brief  : Directed self-checking bench for v_upd_sched (REQ_N=4, depth 5).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_v_upd_sched;
   import v_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_vld;
   id_t   [3:0]   req_id;
   cmd_t  [3:0]   req_cmd;
   key_t  [3:0]   req_key;
   size_t [3:0]   req_size;
   logic [3:0]    req_rdy;
   logic          busy;
   logic          upd_vld;
   id_t           upd_id;
   cmd_t          upd_cmd;
   key_t          upd_key;
   size_t         upd_size;
   logic          stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   v_upd_sched #(
      .REQ_N        (4),
      .HAZARD_DEPTH (5)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_req_vld       (req_vld),
      .i_req_prod_id   (req_id),
      .i_req_cmd       (req_cmd),
      .i_req_key       (req_key),
      .i_req_size      (req_size),
      .o_req_rdy       (req_rdy),
      .i_busy          (busy),
      .o_upd_vld_r     (upd_vld),
      .o_upd_prod_id_r (upd_id),
      .o_upd_cmd_r     (upd_cmd),
      .o_upd_key_r     (upd_key),
      .o_upd_size_r    (upd_size),
      .o_stall_r       (stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      busy    = 1'b0;
      req_vld = 4'b0000;
      step();
      rst = 1'b0;
      step();
   endtask

   logic [3:0] b_rdy [8];
   logic [7:0] b_id  [8];

   initial begin
      rst      = 1'b1;
      busy     = 1'b1;
      req_vld  = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         req_id[i]   = id_t'(i + 1);
         req_cmd[i]  = cmd_t'(i + 1);
         req_key[i]  = key_t'(16'h0100 + i);
         req_size[i] = size_t'(12'h010 + i);
      end

      // ---- reset values, then busy held for 10 cycles -------------------
      step();
      step();
      settle();
      chk("rst upd_vld", upd_vld, 0);
      chk("rst stall", stall, 0);
      chk("rst rdy", req_rdy, 4'b0000);
      chk("rst upd_id", upd_id, 0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         settle();
         chk("busy rdy", req_rdy, 4'b0000);
         step();
      end
      busy = 1'b0;
      settle();
      chk("busy_fall rdy", req_rdy, 4'b0000);
      step();
      settle();
      chk("first rdy", req_rdy, 4'b0001);
      chk("first stall", stall, 1);
      step();
      req_vld = 4'b0000;
      settle();
      chk("first upd_vld", upd_vld, 1);
      chk("first upd_id", upd_id, 1);
      chk("first stall clr", stall, 0);
      step();
      settle();
      chk("idle upd_vld", upd_vld, 0);
      chk("idle upd_id hold", upd_id, 1);

      // ---- all four valid, ids 1..4: rotate, then hazard gap -----------
      do_reset();
      b_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
      b_id  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd1, 8'd2};
      req_vld = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         settle();
         chk("rr rdy", req_rdy, b_rdy[k]);
         if (k > 0) begin
            chk("rr upd_vld", upd_vld, b_id[k-1] != 0);
            chk("rr stall", stall, b_id[k-1] == 0);
            if (b_id[k-1] != 0) begin
               chk("rr upd_id", upd_id, b_id[k-1]);
               chk("rr upd_key", upd_key, 16'h00ff + b_id[k-1]);
               chk("rr upd_cmd", upd_cmd, b_id[k-1]);
            end
         end
         step();
      end
      req_vld = 4'b0000;

      // ---- same id on requesters 0 and 1 --------------------------------
      do_reset();
      req_id[0] = 8'd7;
      req_id[1] = 8'd7;
      req_vld   = 4'b0011;
      settle();
      chk("haz t rdy", req_rdy, 4'b0001);
      step();
      req_vld = 4'b0010;
      settle();
      chk("haz t+1 stall", stall, 0);
      chk("haz t+1 upd_id", upd_id, 7);
      for (int k = 1; k <= 5; k++) begin
         settle();
         chk("haz blocked rdy", req_rdy, 4'b0000);
         if (k >= 2) chk("haz stall", stall, 1);
         step();
      end
      settle();
      chk("haz t+6 rdy", req_rdy, 4'b0010);
      chk("haz t+6 stall", stall, 1);
      step();
      req_vld = 4'b0000;
      settle();
      chk("haz t+7 upd_vld", upd_vld, 1);
      chk("haz t+7 upd_id", upd_id, 7);
      chk("haz t+7 stall", stall, 0);

      // ---- blocked requester skipped, lower priority granted -----------
      do_reset();
      req_id[1] = 8'd3;
      req_vld   = 4'b0010;
      settle();
      chk("skip seed rdy", req_rdy, 4'b0010);
      step();
      req_id[2] = 8'd3;
      req_id[3] = 8'd9;
      req_vld   = 4'b1100;
      settle();
      chk("skip rdy", req_rdy, 4'b1000);
      step();
      req_id[0] = 8'd20;
      req_id[3] = 8'd21;
      req_vld   = 4'b1101;
      settle();
      chk("skip upd_id", upd_id, 9);
      chk("skip ptr wrap rdy", req_rdy, 4'b0001);
      step();
      req_vld = 4'b0000;

      // ---- busy pulse mid-stream ----------------------------------------
      do_reset();
      req_id[0] = 8'd10;
      req_id[1] = 8'd11;
      req_vld   = 4'b0011;
      settle();
      chk("hold t0 rdy", req_rdy, 4'b0001);
      step();
      req_id[0] = 8'd12;
      busy      = 1'b1;
      settle();
      chk("hold t1 rdy", req_rdy, 4'b0000);
      chk("hold t1 upd_id", upd_id, 10);
      step();
      settle();
      chk("hold t2 rdy", req_rdy, 4'b0000);
      chk("hold t2 upd_vld", upd_vld, 0);
      chk("hold t2 stall", stall, 1);
      step();
      settle();
      chk("hold t3 rdy", req_rdy, 4'b0000);
      step();
      busy = 1'b0;
      step();
      settle();
      chk("hold resume rdy", req_rdy, 4'b0010);
      step();
      req_vld = 4'b0000;

      // ---- reset while grants flow --------------------------------------
      do_reset();
      req_id[0] = 8'd30;
      req_id[1] = 8'd31;
      req_vld   = 4'b0011;
      settle();
      chk("mrst t0 rdy", req_rdy, 4'b0001);
      step();
      req_id[0] = 8'd32;
      rst       = 1'b1;
      settle();
      chk("mrst t1 rdy", req_rdy, 4'b0000);
      chk("mrst t1 upd_id", upd_id, 30);
      step();
      rst = 1'b0;
      settle();
      chk("mrst t2 upd_vld", upd_vld, 0);
      chk("mrst t2 stall", stall, 0);
      chk("mrst t2 upd_id", upd_id, 0);
      chk("mrst t2 rdy", req_rdy, 4'b0000);
      step();
      req_id[0] = 8'd30;
      settle();
      chk("mrst t3 rdy", req_rdy, 4'b0001);
      step();
      req_vld = 4'b0000;
      settle();
      chk("mrst t4 upd_id", upd_id, 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
